// File: rtl/sb_tx_sched_pkg.sv
// Shared types and constants for the sideband TX message scheduler.
package sb_tx_sched_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_HDR, WAIT_DATA, DONE} state_t;

  localparam int SB_HDR_W  = 62;
  localparam int SB_DATA_W = 64;

  localparam int SRC_LTSM = 0;
  localparam int SRC_CPL  = 1;
  localparam int SRC_REG  = 2;
endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module sb_rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end
endmodule

// File: rtl/sb_tx_msg_scheduler.sv
// Shares the sideband framer among message sources: RR arbitration, phase
// tracking of the framer output, per-source ack and a per-phase watchdog.
module sb_tx_msg_scheduler
  import sb_tx_sched_pkg::*;
#(
  parameter  int NUM_SRC        = 3,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_SRC-1:0]             i_req,
  input  logic [NUM_SRC*SB_HDR_W-1:0]    i_header,
  input  logic [NUM_SRC*SB_DATA_W-1:0]   i_data,
  input  logic [NUM_SRC-1:0]             i_has_data,
  input  logic                           i_packet_valid,
  output logic [SB_HDR_W-1:0]            o_header,
  output logic [SB_DATA_W-1:0]           o_data,
  output logic                           o_header_valid,
  output logic                           o_d_valid,
  output logic                           o_data_valid,
  output logic [NUM_SRC-1:0]             o_ack,
  output logic                           o_timeout_err,
  output logic                           o_busy,
  output logic [IW-1:0]                  o_grant_idx
);
  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [TW-1:0] timer;
  logic [NUM_SRC-1:0] arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_valid;
  logic          load, waiting, timer_exp, expire, fin, ack_set, adv_ptr;

  sb_rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign timer_exp = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arb_valid) state_nxt = WAIT_HDR;
      WAIT_HDR:  if (i_packet_valid) state_nxt = o_data_valid ? WAIT_DATA : DONE;
                 else if (timer_exp) state_nxt = IDLE;
      WAIT_DATA: if (i_packet_valid) state_nxt = DONE;
                 else if (timer_exp) state_nxt = IDLE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // o_data_valid doubles as the registered has_data of the active message.
  always_comb begin
    waiting = (state == WAIT_HDR) || (state == WAIT_DATA);
    load    = (state == IDLE) && arb_valid;
    expire  = waiting && !i_packet_valid && timer_exp;
    fin     = i_packet_valid &&
              (((state == WAIT_HDR) && !o_data_valid) || (state == WAIT_DATA));
    ack_set = fin || expire;
    adv_ptr = (state == DONE) || expire;
    o_busy  = (state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_header       <= '0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_grant_idx    <= '0;
      o_header_valid <= 1'b0;
      o_d_valid      <= 1'b0;
      o_timeout_err  <= 1'b0;
      o_ack          <= '0;
      ptr            <= '0;
      timer          <= '0;
    end else begin
      o_header_valid <= load;
      o_d_valid      <= load;
      o_timeout_err  <= expire;
      o_ack          <= ack_set ? (NUM_SRC'(1) << o_grant_idx) : '0;
      if (load) begin
        o_header     <= i_header[int'(arb_idx)*SB_HDR_W +: SB_HDR_W];
        o_data       <= i_has_data[arb_idx] ? i_data[int'(arb_idx)*SB_DATA_W +: SB_DATA_W] : '0;
        o_data_valid <= i_has_data[arb_idx];
        o_grant_idx  <= arb_idx;
      end
      if (adv_ptr)
        ptr <= (int'(o_grant_idx) == NUM_SRC - 1) ? '0 : o_grant_idx + IW'(1);
      if (load || i_packet_valid) timer <= '0;
      else if (waiting)           timer <= timer + TW'(1);
    end
  end
endmodule

// File: tb/tb_sb_tx_msg_scheduler.sv
// Directed self-checking bench for sb_tx_msg_scheduler (short watchdog).
module tb_sb_tx_msg_scheduler;
  import sb_tx_sched_pkg::*;

  localparam int N  = 3;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, has;
  logic [N*62-1:0]  hdr;
  logic [N*64-1:0]  data;
  logic             pv;
  logic [61:0]      o_header;
  logic [63:0]      o_data;
  logic             hv, dv, dval, terr, busy;
  logic [N-1:0]     ack;
  logic [1:0]       gidx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sb_tx_msg_scheduler #(.NUM_SRC(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_header(hdr), .i_data(data),
    .i_has_data(has), .i_packet_valid(pv), .o_header(o_header), .o_data(o_data),
    .o_header_valid(hv), .o_d_valid(dv), .o_data_valid(dval), .o_ack(ack),
    .o_timeout_err(terr), .o_busy(busy), .o_grant_idx(gidx)
  );

  task automatic wait_hv(output int n);
    n = 0;
    while (hv !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; has = '0; hdr = '0; data = '0; pv = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hv, dv, dval, terr, busy, ack, gidx, o_header, o_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got hv=%b dv=%b busy=%b ack=%b hdr=%h data=%h exp all 0",
               hv, dv, busy, ack, o_header, o_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_data;
    hdr[SRC_CPL*62 +: 62] = 62'h15;
    data[SRC_CPL*64 +: 64] = 64'h1234_5678;
    has = '0; req = 3'b010;
    @(negedge clk);
    checks++;
    if ({hv, dv, busy} !== 3'b111) begin
      failures++; $display("FAIL nodata_pulses got hv=%b dv=%b busy=%b exp 111", hv, dv, busy);
    end
    checks++;
    if (o_data !== 64'h0 || dval !== 1'b0) begin
      failures++; $display("FAIL nodata_zero got data=%h dval=%b exp 0/0", o_data, dval);
    end
    checks++;
    if (o_header !== 62'h15 || gidx !== 2'd1) begin
      failures++; $display("FAIL nodata_hdr got hdr=%h idx=%0d exp 15/1", o_header, gidx);
    end
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (ack !== 3'b010 || hv !== 1'b0 || dv !== 1'b0) begin
      failures++; $display("FAIL nodata_ack got ack=%b hv=%b dv=%b exp 010/0/0", ack, hv, dv);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      failures++; $display("FAIL nodata_idle got ack=%b busy=%b exp 000/0", ack, busy);
    end
  endtask

  task automatic test_with_data;
    has = 3'b100;
    hdr[SRC_REG*62 +: 62] = 62'h2A;
    data[SRC_REG*64 +: 64] = 64'hDEAD_BEEF_0000_0001;
    req = 3'b100;
    @(negedge clk);
    checks++;
    if (hv !== 1'b1 || dval !== 1'b1 || o_data !== 64'hDEAD_BEEF_0000_0001 || gidx !== 2'd2) begin
      failures++;
      $display("FAIL data_load got hv=%b dval=%b data=%h idx=%0d exp 1/1/deadbeef00000001/2",
               hv, dval, o_data, gidx);
    end
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (ack !== 3'b000 || busy !== 1'b1) begin
      failures++; $display("FAIL data_hdr_phase got ack=%b busy=%b exp 000/1", ack, busy);
    end
    @(negedge clk);
    checks++;
    if (ack !== 3'b000) begin
      failures++; $display("FAIL data_gap got ack=%b exp 000", ack);
    end
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (ack !== 3'b100 || o_data !== 64'hDEAD_BEEF_0000_0001) begin
      failures++; $display("FAIL data_ack got ack=%b data=%h exp 100/held", ack, o_data);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int exp_o [5] = '{0, 1, 2, 0, 1};
    int cnt [3] = '{0, 0, 0};
    int n;
    logic [N-1:0] exp_ack;
    has = '0;
    hdr[0 +: 62] = 62'hA0; hdr[62 +: 62] = 62'hA1; hdr[124 +: 62] = 62'hA2;
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      wait_hv(n);
      checks++;
      if (n >= 50) begin
        failures++; $display("FAIL b2b_timeout_wait got n=%0d exp <50", n);
      end
      checks++;
      if (int'(gidx) !== exp_o[i] || o_header !== hdr[exp_o[i]*62 +: 62]) begin
        failures++;
        $display("FAIL b2b_order[%0d] got idx=%0d hdr=%h exp idx=%0d", i, gidx, o_header, exp_o[i]);
      end
      pv = 1'b1; @(negedge clk); pv = 1'b0;
      exp_ack = '0; exp_ack[exp_o[i]] = 1'b1;
      checks++;
      if (ack !== exp_ack) begin
        failures++; $display("FAIL b2b_ack[%0d] got ack=%b exp %b", i, ack, exp_ack);
      end
      for (int s = 0; s < 3; s++) if (ack[s] === 1'b1) cnt[s]++;
      if (i == 4) req = '0;
    end
    checks++;
    if (cnt[0] !== 2 || cnt[1] !== 2 || cnt[2] !== 1) begin
      failures++; $display("FAIL b2b_counts got %0d/%0d/%0d exp 2/2/1", cnt[0], cnt[1], cnt[2]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_spurious;
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (busy !== 1'b0 || ack !== 3'b000 || hv !== 1'b0) begin
      failures++; $display("FAIL spurious got busy=%b ack=%b hv=%b exp 0/000/0", busy, ack, hv);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 3'b000) begin
      failures++; $display("FAIL spurious_after got busy=%b ack=%b exp 0/000", busy, ack);
    end
  endtask

  task automatic test_timeout;
    int n;
    has = '0; req = 3'b001;
    wait_hv(n);
    checks++;
    if (n >= 50 || gidx !== 2'd0) begin
      failures++; $display("FAIL to_load got n=%0d idx=%0d exp <50/0", n, gidx);
    end
    n = 0;
    while (terr !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TO) begin
      failures++; $display("FAIL to_latency got %0d exp %0d", n, TO);
    end
    checks++;
    if (ack !== 3'b001 || busy !== 1'b0) begin
      failures++; $display("FAIL to_ack got ack=%b busy=%b exp 001/0", ack, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (terr !== 1'b0 || ack !== 3'b000) begin
      failures++; $display("FAIL to_pulse got terr=%b ack=%b exp 0/000", terr, ack);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int bad_ack = 0;
    has = 3'b010;
    data[SRC_CPL*64 +: 64] = 64'hCAFE;
    req = 3'b010;
    wait_hv(n);
    checks++;
    if (n >= 50 || gidx !== 2'd1) begin
      failures++; $display("FAIL rst_mid_load got n=%0d idx=%0d exp <50/1", n, gidx);
    end
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (busy !== 1'b1 || ack !== 3'b000) begin
      failures++; $display("FAIL rst_mid_wait got busy=%b ack=%b exp 1/000", busy, ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hv, dv, dval, terr, busy, ack, gidx, o_header, o_data} !== '0) begin
      failures++;
      $display("FAIL rst_mid_async got busy=%b dval=%b idx=%0d hdr=%h data=%h exp all 0",
               busy, dval, gidx, o_header, o_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack !== 3'b000) bad_ack++;
    end
    checks++;
    if (bad_ack !== 0) begin
      failures++; $display("FAIL rst_mid_noack got %0d ack cycles exp 0", bad_ack);
    end
    has = '0; req = 3'b101;
    rst_n = 1'b1;
    wait_hv(n);
    checks++;
    if (n >= 50 || gidx !== 2'd0) begin
      failures++; $display("FAIL rst_mid_ptr got n=%0d idx=%0d exp <50/0", n, gidx);
    end
    pv = 1'b1; @(negedge clk); pv = 1'b0;
    checks++;
    if (ack !== 3'b001) begin
      failures++; $display("FAIL rst_mid_ack got ack=%b exp 001", ack);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_no_data;
    test_with_data;
    test_back_to_back;
    test_spurious;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sb_tx_msg_scheduler.md
# sb_tx_msg_scheduler

Sideband TX scheduler sharing the single sideband packet-framing stage between several message sources (LTSM messages, completions, register-access requests). It arbitrates round-robin among pending requests and hands the winner's header and data to the framer as one-cycle valid pulses. It then tracks the framer's emitted phases (header, and data if present) and acknowledges the source when the packet is fully handed off. A watchdog aborts a transaction whose phases never appear.

## Interface
Parameters:
- NUM_SRC, 3, number of requesters (index 0 = LTSM, 1 = completion, 2 = register access)
- TIMEOUT_CYCLES, 1024, max cycles waiting for any single framer phase

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  NUM_SRC  per-source request level
- i_header  in  NUM_SRC*62  per-source header, source k at [62k+61:62k]
- i_data  in  NUM_SRC*64  per-source data payload, source k at [64k+63:64k]
- i_has_data  in  NUM_SRC  per-source: message carries a data phase
- i_packet_valid  in  1  framer phase-emitted pulse, one per phase
- o_header  out  62  header to framer
- o_data  out  64  data to framer; zero when the message has no data
- o_header_valid  out  1  one-cycle header-load pulse
- o_d_valid  out  1  one-cycle data-load pulse; asserted for every message
- o_data_valid  out  1  message-with-data flag, valid with o_d_valid
- o_ack  out  NUM_SRC  one-cycle per-source completion pulse
- o_timeout_err  out  1  one-cycle abort pulse
- o_busy  out  1  high in any state other than IDLE
- o_grant_idx  out  clog2(NUM_SRC)  index of the current or last winner

## Operation
- Reset values: all outputs 0, state IDLE, RR pointer 0 (source 0 highest priority), timer 0.
- Source contract:
  - Source holds i_req, i_header, i_data and i_has_data stable until its o_ack.
  - Dropping i_req after grant does not cancel the transaction; the payload is already captured.
- States:
  - IDLE: any i_req set → pick the winner round-robin, starting at the index after the last served. Register the winner's header, data (zeroed if !has_data) and has_data. Pulse o_header_valid, o_d_valid, and o_data_valid = has_data. Go to WAIT_HDR.
  - WAIT_HDR: on i_packet_valid → WAIT_DATA if has_data, else DONE.
  - WAIT_DATA: on i_packet_valid → DONE.
  - DONE: pulse o_ack[winner]; pointer ← winner+1 (wraps NUM_SRC-1 → 0); go to IDLE.
- o_d_valid is always pulsed because the framer needs data parity ready even for header-only messages.
- Watchdog:
  - Timer clears on entry to WAIT_HDR/WAIT_DATA and on each i_packet_valid; it increments otherwise in those states.
  - Reaching TIMEOUT_CYCLES-1 pulses o_timeout_err together with o_ack[winner], advances the pointer, and returns to IDLE.
- i_packet_valid in IDLE or DONE is ignored.
- Requests arriving during a transaction wait; they are considered only in IDLE.
- Reset asserted mid-transaction: immediate return to reset values; no ack is issued.

## Timing
- Cycle 0 (IDLE, req seen) → cycle 1: o_header_valid / o_d_valid high for exactly one cycle, o_busy high.
- Ack comes 1 cycle after the final i_packet_valid (DONE state), then IDLE.
- Minimum spacing between header_valid pulses of back-to-back messages: the phase latency plus 3 cycles.
- o_header, o_data and o_data_valid hold their registered values from load until the next load.
- Arbitration is registered; no combinational path from i_req to any output.

## Structure
- Package sb_tx_sched_pkg:
  - state enum {IDLE, WAIT_HDR, WAIT_DATA, DONE}
  - localparams SB_HDR_W = 62 and SB_DATA_W = 64
  - source index constants SRC_LTSM = 0, SRC_CPL = 1, SRC_REG = 2
- Sub-module sb_rr_arbiter: request vector plus pointer in, one-hot grant and index out, purely combinational. The pointer register lives in the scheduler.

## Test plan
- Single no-data request, source 1 (header 62'h15): one header_valid and one d_valid pulse with o_data = 0 and o_data_valid = 0. One i_packet_valid → o_ack = 3'b010 exactly 1 cycle later.
- Source 2 with data (64'hDEAD_BEEF_0000_0001): o_data_valid = 1. No ack after the first i_packet_valid; o_ack = 3'b100 one cycle after the second.
- All three requests held continuously: grant order 0, 1, 2, 0, 1; each source acked once per round.
- No i_packet_valid after load: o_timeout_err and o_ack[winner] pulse at cycle TIMEOUT_CYCLES after entering WAIT_HDR, then IDLE.
- i_rst_n dropped in WAIT_DATA: all outputs 0 asynchronously, no ack. After release, a pending source 2 request is served with pointer = 0, so source 0 wins if also requesting.
- Spurious i_packet_valid in IDLE: no state change, no ack.
